// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: FSM states, inst bus field positions, the idle instruction word
// and the drain timeout length shared by core_ctrl and its input-SRAM reader.
package core_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_FILL,
      S_W_LOAD,
      S_W_GAP,
      S_X_FILL,
      S_X_EXEC,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int INST_W        = 35;
   localparam int INST_CEN_PMEM = 32;
   localparam int INST_WEN_PMEM = 31;
   localparam int INST_A_PMEM   = 20;
   localparam int INST_CEN_XMEM = 19;
   localparam int INST_A_XMEM   = 7;
   localparam int INST_OFIFO_RD = 6;
   localparam int INST_L0_RD    = 3;
   localparam int INST_L0_WR    = 2;
   localparam int INST_EXECUTE  = 1;
   localparam int INST_LOAD     = 0;

   // Both SRAMs deselected with write-enable inactive; every other field low.
   localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

   localparam int DRAIN_TIMEOUT = 1024;

   function automatic logic timeout_hit(input logic [9:0] idle_cycles);
      return idle_cycles == 10'(DRAIN_TIMEOUT - 1);
   endfunction

endpackage

// File: rtl/core_ctrl_xreader.sv
// core_ctrl_xreader: while go is high, issues count sequential input-SRAM reads
// from base, echoes each read one cycle later as the l0_wr strobe, then flags finish.
module core_ctrl_xreader
   import core_ctrl_pkg::*;
#(
   parameter int addr_bw = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic [addr_bw-1:0] base,
   input  logic [addr_bw-1:0] count,
   output logic               rd,
   output logic [addr_bw-1:0] addr,
   output logic               wr,
   output logic               finish
);

   logic [addr_bw-1:0] idx;
   logic               rd_q;

   // Outputs describe the instruction the parent registers at the coming edge.
   assign rd     = go && (idx != count);
   assign finish = go && (idx == count);
   assign addr   = base + idx;
   assign wr     = rd_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx  <= '0;
         rd_q <= 1'b0;
      end else if (rd) begin
         idx  <= idx + addr_bw'(1);
         rd_q <= 1'b1;
      end else begin
         idx  <= '0;
         rd_q <= 1'b0;
      end
   end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: drives the core inst bus through one weight-stationary tile pass.
// Define CORE_CTRL_DRAIN_TIMEOUT_EN to abort a stalled drain and raise a sticky err.
module core_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_bw = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [addr_bw-1:0] w_base,
   input  logic [addr_bw-1:0] x_base,
   input  logic [addr_bw-1:0] p_base,
   input  logic [addr_bw-1:0] n_x,
   input  logic               ofifo_valid,
   output logic [INST_W-1:0]  inst,
   output logic               busy,
   output logic               done,
   output logic               err,
   output state_t             state
);

   localparam logic [addr_bw-1:0] ONE      = addr_bw'(1);
   localparam logic [addr_bw-1:0] COL_LAST = addr_bw'(col - 1);
   localparam logic [addr_bw-1:0] GAP_LAST = addr_bw'(row + col - 1);

   logic [addr_bw-1:0] w_base_q, x_base_q, p_base_q, n_x_q, cnt;
   logic               xr_go, xr_rd, xr_wr, xr_finish;
   logic [addr_bw-1:0] xr_base, xr_count, xr_addr;

   assign xr_go    = (state == S_W_FILL) || (state == S_X_FILL);
   assign xr_base  = (state == S_W_FILL) ? w_base_q : x_base_q;
   assign xr_count = (state == S_W_FILL) ? addr_bw'(col) : n_x_q;

   core_ctrl_xreader #(.addr_bw(addr_bw)) u_xreader (
      .clk    (clk),
      .reset  (reset),
      .go     (xr_go),
      .base   (xr_base),
      .count  (xr_count),
      .rd     (xr_rd),
      .addr   (xr_addr),
      .wr     (xr_wr),
      .finish (xr_finish)
   );

`ifdef CORE_CTRL_DRAIN_TIMEOUT_EN
   logic [9:0] to_cnt;
`else
   assign err = 1'b0;
`endif

   // Every output is a flop; a state's decision shows on inst one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         inst     <= INST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         w_base_q <= '0;
         x_base_q <= '0;
         p_base_q <= '0;
         n_x_q    <= '0;
`ifdef CORE_CTRL_DRAIN_TIMEOUT_EN
         err      <= 1'b0;
         to_cnt   <= '0;
`endif
      end else begin
         inst <= INST_IDLE;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               busy <= 1'b0;
               if (start && (n_x != '0)) begin
                  busy     <= 1'b1;
                  w_base_q <= w_base;
                  x_base_q <= x_base;
                  p_base_q <= p_base;
                  n_x_q    <= n_x;
                  cnt      <= '0;
                  state    <= S_W_FILL;
               end
            end
            S_W_FILL, S_X_FILL: begin
               inst[INST_CEN_XMEM] <= ~xr_rd;
               if (xr_rd) inst[INST_A_XMEM +: addr_bw] <= xr_addr;
               inst[INST_L0_WR] <= xr_wr;
               if (xr_finish) state <= (state == S_W_FILL) ? S_W_LOAD : S_X_EXEC;
            end
            S_W_LOAD: begin
               inst[INST_L0_RD] <= 1'b1;
               inst[INST_LOAD]  <= 1'b1;
               if (cnt == COL_LAST) begin
                  cnt   <= '0;
                  state <= S_W_GAP;
               end else cnt <= cnt + ONE;
            end
            S_W_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= S_X_FILL;
               end else cnt <= cnt + ONE;
            end
            S_X_EXEC: begin
               inst[INST_L0_RD]   <= 1'b1;
               inst[INST_EXECUTE] <= 1'b1;
               if (cnt == n_x_q - ONE) begin
                  cnt   <= '0;
                  state <= S_DRAIN;
               end else cnt <= cnt + ONE;
            end
            S_DRAIN: begin
               // cnt only advances on accepted rows, so pmem addresses stay contiguous.
               if (ofifo_valid) begin
                  inst[INST_OFIFO_RD]              <= 1'b1;
                  inst[INST_CEN_PMEM]              <= 1'b0;
                  inst[INST_WEN_PMEM]              <= 1'b0;
                  inst[INST_A_PMEM +: addr_bw]     <= p_base_q + cnt;
                  if (cnt == n_x_q - ONE) begin
                     cnt   <= '0;
                     state <= S_DONE;
                  end else cnt <= cnt + ONE;
               end
`ifdef CORE_CTRL_DRAIN_TIMEOUT_EN
               if (ofifo_valid) begin
                  to_cnt <= '0;
               end else if (timeout_hit(to_cnt)) begin
                  to_cnt <= '0;
                  err    <= 1'b1;
                  cnt    <= '0;
                  state  <= S_DONE;
               end else begin
                  to_cnt <= to_cnt + 10'd1;
               end
`endif
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: randomized and directed tile passes against a phase-level reference
// model; expected inst/busy/done/err words are queued and popped by a per-cycle monitor.
module tb_core_ctrl;
   import core_ctrl_pkg::*;

   localparam int ROW = 8;
   localparam int COL = 8;
   localparam int AW  = 11;
   localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] w_base, x_base, p_base, n_x;
   logic          ofifo_valid;
   logic [34:0]   inst;
   logic          busy, done, err;
   state_t        state;

   core_ctrl #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .w_base      (w_base),
      .x_base      (x_base),
      .p_base      (p_base),
      .n_x         (n_x),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .state       (state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic        mon_en = 1'b0;
   logic [37:0] exp_q[$];
   bit          vbit[8192];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Instruction words built straight from the field map.
   function automatic logic [34:0] w_read(input logic [AW-1:0] a, input bit wr);
      logic [34:0] w;
      w = IDLE_W; w[19] = 1'b0; w[17:7] = a; w[2] = wr;
      return w;
   endfunction

   function automatic logic [34:0] w_trail();
      logic [34:0] w;
      w = IDLE_W; w[2] = 1'b1;
      return w;
   endfunction

   function automatic logic [34:0] w_load();
      logic [34:0] w;
      w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
      return w;
   endfunction

   function automatic logic [34:0] w_exec();
      logic [34:0] w;
      w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
      return w;
   endfunction

   function automatic logic [34:0] w_write(input logic [AW-1:0] a);
      logic [34:0] w;
      w = IDLE_W; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = a; w[6] = 1'b1;
      return w;
   endfunction

   function automatic void push(input bit b, input bit d, input logic [34:0] w);
      exp_q.push_back({1'b0, b, d, w});
   endfunction

   // Entry i is the expected output in the cycle after edge t+i (t = accepting edge).
   function automatic void model_pass(input logic [AW-1:0] w, input logic [AW-1:0] x,
                                      input logic [AW-1:0] p, input int nx, input bit full);
      int m, j;
      push(1, 0, IDLE_W);
      for (int k = 0; k < COL; k++) push(1, 0, w_read(w + AW'(k), k > 0));
      push(1, 0, w_trail());
      for (int k = 0; k < COL; k++) push(1, 0, w_load());
      for (int k = 0; k < ROW + COL; k++) push(1, 0, IDLE_W);
      for (int k = 0; k < nx; k++) push(1, 0, w_read(x + AW'(k), k > 0));
      push(1, 0, w_trail());
      for (int k = 0; k < nx; k++) push(1, 0, w_exec());
      if (full) begin
         m = 1 + (COL + 1) + COL + (ROW + COL) + (nx + 1) + nx;
         j = 0;
         while (j < nx) begin
            if (vbit[m]) begin
               push(1, 0, w_write(p + AW'(j)));
               j++;
            end else push(1, 0, IDLE_W);
            m++;
         end
         push(1, 1, IDLE_W);
         push(0, 0, IDLE_W);
      end
   endfunction

   // ---------------- monitor ----------------
   initial begin
      logic [37:0] e;
      forever begin
         @(posedge clk); #1;
         if (mon_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = {3'b000, IDLE_W};
            check("inst_seq", {err, busy, done, inst}, e);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic reset_abort();
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      check("rst_inst", inst, IDLE_W);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_state", state, S_IDLE);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   // vmode: 0 all valid, 1 pattern 1,0,0 repeating, 2 random, 3 never valid
   task automatic run_pass(input logic [AW-1:0] w, input logic [AW-1:0] x, input logic [AW-1:0] p,
                           input int nx, input int vmode, input bit full, input int gap_k,
                           input int abort_k, output int t_acc);
      int k;
      for (int i = 0; i < 8192; i++) begin
         case (vmode)
            0:       vbit[i] = 1'b1;
            1:       vbit[i] = ((i % 3) == 0);
            2:       vbit[i] = 1'($urandom_range(0, 1));
            default: vbit[i] = 1'b0;
         endcase
      end
      @(negedge clk);
      w_base = w; x_base = x; p_base = p; n_x = AW'(nx); start = 1'b1;
      t_acc = cyc + 1;
      model_pass(w, x, p, nx, full);
      @(negedge clk);
      start = 1'b0;
      w_base = AW'($urandom); x_base = AW'($urandom); p_base = AW'($urandom); n_x = AW'($urandom);
      ofifo_valid = vbit[1];
      k = 1;
      while (exp_q.size() > 0 && k < 6000) begin
         @(negedge clk);
         k++;
         ofifo_valid = vbit[k];
         start = (k == gap_k);
         if (k == abort_k) begin
            reset_abort();
            return;
         end
      end
      start = 1'b0;
      check("pass_drained", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t_acc, ld, nx;
      bit seen;
      reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
      w_base = '0; x_base = '0; p_base = '0; n_x = '0;
      repeat (3) @(negedge clk);
      check("reset_inst", inst, IDLE_W);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_err", err, 1'b0);
      check("reset_state", state, S_IDLE);
      reset = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      // n_x == 0 must be ignored; the monitor expects idle outputs throughout.
      n_x = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);

      // Directed pass with a stray start during the weight gap.
      run_pass(11'h010, 11'h100, 11'h200, 16, 0, 1'b1, 2 * COL + 4, 0, t_acc);
      // Sparse ofifo_valid, pmem addresses wrapping past 2047.
      run_pass(11'h020, 11'h300, 11'h7FE, 5, 1, 1'b1, 0, 0, t_acc);
      // Single activation, every base at the top of the address space.
      run_pass(11'h7FF, 11'h7FF, 11'h7FF, 1, 0, 1'b1, 0, 0, t_acc);

      for (int r = 0; r < 6; r++) begin
         nx = $urandom_range(1, 40);
         run_pass(AW'($urandom), AW'($urandom), AW'($urandom), nx, 2, 1'b1,
                  $urandom_range(2, 60), 0, t_acc);
      end

      // Reset in the middle of X_EXEC, then a clean pass to show recovery.
      run_pass(11'h010, 11'h100, 11'h200, 16, 0, 1'b1, 0, 55, t_acc);
      run_pass(11'h040, 11'h080, 11'h0C0, 3, 0, 1'b1, 0, 0, t_acc);

      // Drain with ofifo_valid held low.
      run_pass(11'h020, 11'h200, 11'h300, 2, 3, 1'b0, 0, 0, t_acc);
      mon_en = 1'b0;
      ld = 1 + (COL + 1) + COL + (ROW + COL) + (2 + 1) + 2;
`ifdef CORE_CTRL_DRAIN_TIMEOUT_EN
      seen = 1'b0;
      for (int i = 0; i < 1200 && !seen; i++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("timeout_done_cycle", cyc - t_acc, ld + 1024);
      check("timeout_err", err, 1'b1);
      @(posedge clk); #1;
      check("timeout_done_pulse", done, 1'b0);
      check("timeout_err_sticky", err, 1'b1);
      check("timeout_state", state, S_IDLE);
`else
      seen = 1'b0;
      repeat (2000) begin
         @(posedge clk); #1;
         if (done || err) seen = 1'b1;
      end
      check("no_timeout_exit", seen, 1'b0);
      check("still_drain", state, S_DRAIN);
      check("still_busy", busy, 1'b1);
      check("no_pmem_write", inst, IDLE_W);
`endif
      @(negedge clk);
      reset_abort();
      repeat (3) @(negedge clk);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
